// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: FSM states,
// register-zero index and the bundled hazard control word.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam hz_ctrl_t HZ_FREEZE  = '{pipe_hold: 1'b1, default: 1'b0};
  localparam hz_ctrl_t HZ_BUBBLE  = '{idex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctrl_t HZ_FLUSH   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_flush: 1'b1, default: 1'b0};
  // Held while in reset: nothing advances and ID/EX carries a NOP.
  localparam hz_ctrl_t HZ_RESET   = '{idex_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector between the load in EX and the instruction in ID.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  output logic              load_use
);

  logic rs_hit, rt_hit;

  assign rs_hit   = (idex_rt == ifid_rs);
  assign rt_hit   = ifid_uses_rt && (idex_rt == ifid_rt);
  // $zero never carries a real dependency, so loads into it are ignored.
  assign load_use = idex_mem_read && (idex_rt != REG_AW'(REG_ZERO)) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: merges memory-wait, taken-branch and load-use hazards
// into pipeline enables, with a memory-wait timeout and a stall-cycle counter.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e     state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            load_use, mem_stall;
  hz_ctrl_t        run_ctrl, ctrl;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .load_use      (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Branch beats load-use: the dependent ID instruction is squashed anyway.
  always_comb begin
    run_ctrl = HZ_DEFAULT;
    if (ex_branch_taken) run_ctrl = HZ_FLUSH;
    else if (load_use)   run_ctrl = HZ_BUBBLE;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ctrl      = HZ_DEFAULT;
    case (state)
      RUN: begin
        if (mem_stall) begin
          ctrl      = HZ_FREEZE;
          state_nxt = MEM_WAIT;
          wait_nxt  = WC_W'(1);
        end else begin
          ctrl = run_ctrl;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl = HZ_FREEZE;
          if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
            state_nxt = ERR;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          ctrl      = run_ctrl;
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERR:     ctrl = HZ_FREEZE;
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
    if (!rst_n) ctrl = HZ_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      timeout_err <= timeout_err || (state_nxt == ERR);
      if (!ctrl.pc_write && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign pipe_hold   = ctrl.pipe_hold;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It merges three hazard sources into one coherent set of pipeline-register enables and bubble/flush controls, applied with a fixed priority. The sources are load-use data hazards between ID/EX and IF/ID, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It sits beside the pipeline registers, drives the PC and IF/ID write enables and the ID/EX bubble mux, and adds a memory-wait timeout and a stall-cycle counter.

## Interface
- REG_AW, 5, register-index width
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (≥1)
- CNT_W, 16, stall counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- idex_mem_read  in  1  instruction in EX is a load
- idex_rt  in  REG_AW  load destination register
- ifid_rs, ifid_rt  in  REG_AW  source registers of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage issuing a data access this cycle
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- idex_bubble  out  1  insert NOP controls into ID/EX
- ifid_flush, idex_flush  out  1  clear IF/ID, ID/EX to NOP
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- timeout_err  out  1  sticky memory-timeout flag
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- load_use = idex_mem_read && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- mem_stall = mem_req && !mem_ready.
- Default outputs (no hazard): pc_write=1, ifid_write=1, all others 0.
- States: RUN, MEM_WAIT, ERR. Outputs are Mealy (state + current inputs).
- RUN, priority high→low:
  - mem_stall: pc_write=0, ifid_write=0, pipe_hold=1. Next state MEM_WAIT, wait_cnt←1.
  - ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1. Any concurrent load_use is ignored because the ID instruction is squashed.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1.
- MEM_WAIT:
  - mem_ready=0: full freeze as above, wait_cnt+1. If wait_cnt==MEM_TIMEOUT, go to ERR.
  - mem_ready=1: freeze released this cycle. RUN priority logic is evaluated without the mem_stall term. Next state RUN, wait_cnt←0.
- ERR: full freeze every cycle and timeout_err=1. Left only by reset.
- mem_req with mem_ready in the same cycle is a zero-wait access and causes no stall.
- stall_count increments on every clock edge where pc_write=0 and rst_n=1. It saturates at 2^CNT_W−1 with no wrap.

## Timing
- Hazard outputs are combinational from inputs and state, with zero-cycle latency; state, wait_cnt, timeout_err and stall_count update on the rising clk edge.
- A load-use hazard costs exactly 1 bubble cycle. The next cycle the load is in MEM, load_use deasserts, and forwarding covers the rest.
- A taken branch costs 2 flushed slots in a single flush cycle.
- A memory access with N wait cycles holds for N cycles (mem_ready low) and releases in the cycle mem_ready rises.
- Timeout: timeout_err rises on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle in MEM_WAIT.
- While rst_n=0, asynchronously: state=RUN, wait_cnt=0, stall_count=0, timeout_err=0, pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, idex_flush=0, pipe_hold=0.
- Reset mid-MEM_WAIT or in ERR returns to RUN. The first post-reset cycle uses default outputs.

## Structure
- Shared package mips_pipe_pkg holds the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and REG_ZERO constant; other pipeline control blocks reuse it.
- One combinational sub-module, load_use_detect, computes load_use. The FSM, wait counter and stall counter live in the top module.

## Test plan
- Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 → one cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1. The same with idex_rt=0 → no stall.
- ifid_rt match gating: idex_rt=9, ifid_rt=9, ifid_uses_rt=0 → no stall; ifid_uses_rt=1 → stall.
- Branch and load-use together: ex_branch_taken=1 with load_use=1 → ifid_flush=idex_flush=1, pc_write=1, idex_bubble=0.
- Memory wait with a coincident branch: mem_req=1, mem_ready low for 3 cycles, ex_branch_taken=1 throughout → pipe_hold=1 for 3 cycles with no flush. In the 4th cycle (ready) flush occurs and hold drops; stall_count=3.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 → timeout_err=1 after the 4th wait cycle, freeze persists. Pulsing rst_n low → timeout_err=0, state RUN.
- Counter saturation with CNT_W=4: 20 stall cycles → stall_count=15 and held.
